// File: rtl/i_fetch.sv
// ---------------------------------------------------------------------------
// i_fetch -- instruction-fetch stage of the five-stage pipeline.
//
// Owns the program counter, issues reads to the synchronous instruction
// memory and drives the IF/ID pipeline register that feeds i_decode. A
// one-entry hold buffer catches the word that returns while decode is
// frozen, so no fetched word is ever lost or duplicated across stalls.
//
// Parameters:
//   RESET_PC       PC value loaded on reset
//   NOP_WORD       bubble instruction injected into IF/ID
//
// Ports:
//   clk            single clock, rising edge
//   reset          asynchronous, active-high reset
//   reg_lock       hazard stall from decode (decode not advancing)
//   reg_lock_if    decode-requested fetch freeze (link sequence)
//   jump_or_branch redirect request from decode (combinational)
//   target         redirect address (low two bits ignored)
//   imem_rd        instruction-memory read strobe
//   imem_addr      word-aligned read address
//   imem_data      read data, valid one cycle after imem_rd
//   instruction    IF/ID instruction register
//   pc_plus_four   IF/ID address of the instruction plus 4
//   if_valid       1 when IF/ID holds a fetched word, 0 for a bubble
// ---------------------------------------------------------------------------
module i_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h5400_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        reg_lock,
    input  logic        reg_lock_if,
    input  logic        jump_or_branch,
    input  logic [31:0] target,
    output logic        imem_rd,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] instruction,
    output logic [31:0] pc_plus_four,
    output logic        if_valid
);

    // Force an address onto a word boundary.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    logic [31:0] pc_r;
    logic        inflight_r;
    logic [31:0] inflight_pc_r;
    logic        hold_valid_r;
    logic [31:0] hold_word_r;
    logic [31:0] hold_pc_r;
    logic [31:0] instr_r;
    logic [31:0] ppf_r;
    logic        valid_r;

    logic        stall_s;
    logic        redirect_s;
    logic        issue_s;

    // A redirect is only honoured when decode itself is advancing; a
    // reg_lock_if freeze still lets the redirect land in the PC.
    assign stall_s    = reg_lock | reg_lock_if;
    assign redirect_s = jump_or_branch & ~reg_lock;
    // Never issue while the hold buffer is occupied: that keeps at most one
    // word outstanding, so the one-entry buffer cannot overflow.
    assign issue_s    = ~reset & ~stall_s & ~redirect_s & ~hold_valid_r;

    assign imem_rd      = issue_s;
    assign imem_addr    = word_align(pc_r);
    assign instruction  = instr_r;
    assign pc_plus_four = ppf_r;
    assign if_valid     = valid_r;

    // PC, outstanding-read tracking, hold buffer and IF/ID register update.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_r          <= word_align(RESET_PC);
            inflight_r    <= 1'b0;
            inflight_pc_r <= 32'h0000_0000;
            hold_valid_r  <= 1'b0;
            hold_word_r   <= 32'h0000_0000;
            hold_pc_r     <= 32'h0000_0000;
            instr_r       <= NOP_WORD;
            ppf_r         <= RESET_PC;
            valid_r       <= 1'b0;
        end else if (redirect_s) begin
            // Squash whatever is returning and whatever is buffered.
            pc_r         <= word_align(target);
            inflight_r   <= 1'b0;
            hold_valid_r <= 1'b0;
            if (!reg_lock_if) begin
                instr_r <= NOP_WORD;
                valid_r <= 1'b0;
            end else begin
                instr_r <= instr_r;
                valid_r <= valid_r;
            end
        end else if (stall_s) begin
            // IF/ID frozen; park the returning word, if any.
            inflight_r <= 1'b0;
            if (inflight_r) begin
                hold_valid_r <= 1'b1;
                hold_word_r  <= imem_data;
                hold_pc_r    <= inflight_pc_r;
            end else begin
                hold_valid_r <= hold_valid_r;
            end
        end else begin
            if (hold_valid_r) begin
                // Drain the buffer this cycle; issue resumes next cycle.
                instr_r      <= hold_word_r;
                ppf_r        <= hold_pc_r + 32'd4;
                valid_r      <= 1'b1;
                hold_valid_r <= 1'b0;
                inflight_r   <= 1'b0;
            end else begin
                if (inflight_r) begin
                    instr_r <= imem_data;
                    ppf_r   <= inflight_pc_r + 32'd4;
                    valid_r <= 1'b1;
                end else begin
                    instr_r <= NOP_WORD;
                    valid_r <= 1'b0;
                end
                pc_r          <= pc_r + 32'd4;
                inflight_r    <= 1'b1;
                inflight_pc_r <= pc_r;
            end
        end
    end

endmodule

// File: tb/tb_i_fetch.sv
// ---------------------------------------------------------------------------
// tb_i_fetch -- self-checking bench for i_fetch.
// The reference model tracks fetches as a queue of outstanding/parked
// addresses and derives expected IF/ID contents from the bench's own memory
// function, independently of the data path through imem_data.
// ---------------------------------------------------------------------------
module tb_i_fetch;

    localparam logic [31:0] NOP = 32'h5400_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        reg_lock;
    logic        reg_lock_if;
    logic        jump_or_branch;
    logic [31:0] target;
    logic        imem_rd;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] instruction;
    logic [31:0] pc_plus_four;
    logic        if_valid;

    logic        reset2;
    logic        tie0 = 1'b0;
    logic [31:0] tie32 = 32'h0000_0000;
    logic        imem_rd2;
    logic [31:0] imem_addr2;
    logic [31:0] imem_data2;
    logic [31:0] instruction2;
    logic [31:0] pc_plus_four2;
    logic        if_valid2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    i_fetch dut (
        .clk(clk), .reset(reset), .reg_lock(reg_lock), .reg_lock_if(reg_lock_if),
        .jump_or_branch(jump_or_branch), .target(target), .imem_rd(imem_rd),
        .imem_addr(imem_addr), .imem_data(imem_data), .instruction(instruction),
        .pc_plus_four(pc_plus_four), .if_valid(if_valid)
    );

    i_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk(clk), .reset(reset2), .reg_lock(tie0), .reg_lock_if(tie0),
        .jump_or_branch(tie0), .target(tie32), .imem_rd(imem_rd2),
        .imem_addr(imem_addr2), .imem_data(imem_data2), .instruction(instruction2),
        .pc_plus_four(pc_plus_four2), .if_valid(if_valid2)
    );

    // Memory contents as a pure function of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]} ^ 32'hA5A5_0F0F;
    endfunction

    // Synchronous memories: garbage on cycles without a read.
    always @(posedge clk) imem_data  <= imem_rd  ? mem_word(imem_addr)  : $urandom();
    always @(posedge clk) imem_data2 <= imem_rd2 ? mem_word(imem_addr2) : $urandom();

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] addr;
        bit          parked;   // word already returned, waiting in the buffer
    } ent_t;

    ent_t        q[$];
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_ppf;
    logic        m_valid;

    task automatic model_reset();
        q.delete();
        m_pc    = 32'h0000_0000;
        m_instr = NOP;
        m_ppf   = 32'h0000_0000;
        m_valid = 1'b0;
    endtask

    function automatic bit model_rd();
        bit stall = reg_lock | reg_lock_if;
        bit redir = jump_or_branch & ~reg_lock;
        bit parked = (q.size() > 0) && q[0].parked;
        return !reset && !stall && !redir && !parked;
    endfunction

    task automatic model_edge(input bit rd);
        ent_t e;
        if (jump_or_branch && !reg_lock) begin
            q.delete();
            m_pc = {target[31:2], 2'b00};
            if (!reg_lock_if) begin
                m_instr = NOP;
                m_valid = 1'b0;
            end
        end else if (reg_lock || reg_lock_if) begin
            foreach (q[i]) q[i].parked = 1'b1;
        end else begin
            if (q.size() > 0) begin
                e       = q.pop_front();
                m_instr = mem_word(e.addr);
                m_ppf   = e.addr + 32'd4;
                m_valid = 1'b1;
            end else begin
                m_instr = NOP;
                m_valid = 1'b0;
            end
            if (rd) begin
                e.addr   = m_pc;
                e.parked = 1'b0;
                q.push_back(e);
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    // One clock cycle: drive at negedge, check strobe, check IF/ID after edge.
    task automatic step(input bit lk, input bit lkif, input bit jb, input logic [31:0] tg);
        bit exp_rd;
        @(negedge clk);
        reset          = 1'b0;
        reg_lock       = lk;
        reg_lock_if    = lkif;
        jump_or_branch = jb;
        target         = tg;
        #1;
        exp_rd = model_rd();
        check("imem_rd", {31'd0, imem_rd}, {31'd0, exp_rd});
        check("imem_addr", imem_addr, m_pc);
        @(posedge clk);
        model_edge(exp_rd);
        #1;
        check("instruction", instruction, m_instr);
        check("pc_plus_four", pc_plus_four, m_ppf);
        check("if_valid", {31'd0, if_valid}, {31'd0, m_valid});
    endtask

    initial begin
        reset = 1'b1; reset2 = 1'b1;
        reg_lock = 1'b0; reg_lock_if = 1'b0; jump_or_branch = 1'b0; target = 32'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_instruction", instruction, NOP);
        check("rst_ppf", pc_plus_four, 32'h0);
        check("rst_if_valid", {31'd0, if_valid}, 32'd0);
        check("rst_imem_rd", {31'd0, imem_rd}, 32'd0);

        // Free run: A/4 after the second edge, then B, C, D.
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        check("tp_first_word", instruction, mem_word(32'h0));
        check("tp_first_ppf", pc_plus_four, 32'd4);
        repeat (4) step(0, 0, 0, 0);

        // Hazard stall for three cycles with a word in flight.
        repeat (3) step(1, 0, 0, 0);
        repeat (3) step(0, 0, 0, 0);

        // Single-cycle redirect to 0x100.
        step(0, 0, 1, 32'h100);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        check("tp_redir_word", instruction, mem_word(32'h100));
        check("tp_redir_ppf", pc_plus_four, 32'h104);
        repeat (2) step(0, 0, 0, 0);

        // Redirect ignored under reg_lock.
        repeat (2) step(1, 0, 1, 32'h300);
        repeat (3) step(0, 0, 0, 0);

        // Redirect held while frozen by reg_lock_if.
        repeat (3) step(0, 1, 1, 32'h200);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        check("tp_frozen_word", instruction, mem_word(32'h200));
        check("tp_frozen_ppf", pc_plus_four, 32'h204);

        // Unaligned target.
        step(0, 0, 1, 32'h103);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        check("tp_unaligned_ppf", pc_plus_four, 32'h104);
        check("tp_unaligned_word", instruction, mem_word(32'h100));

        // Asynchronous reset mid-stall with the hold buffer full.
        repeat (2) step(0, 0, 0, 0);
        repeat (2) step(0, 1, 0, 0);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("arst_instruction", instruction, NOP);
        check("arst_ppf", pc_plus_four, 32'h0);
        check("arst_if_valid", {31'd0, if_valid}, 32'd0);
        check("arst_imem_rd", {31'd0, imem_rd}, 32'd0);
        model_reset();
        @(posedge clk);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        check("arst_first_word", instruction, mem_word(32'h0));

        // Randomized traffic.
        for (int i = 0; i < 500; i++) begin
            step(($urandom % 5) == 0, ($urandom % 7) == 0, ($urandom % 6) == 0, $urandom());
        end

        // PC wrap on the second instance.
        @(negedge clk);
        reset2 = 1'b0;
        #1;
        check("wrap_rd0", {31'd0, imem_rd2}, 32'd1);
        check("wrap_addr0", imem_addr2, 32'hFFFF_FFF8);
        @(posedge clk); #1;
        check("wrap_bubble", instruction2, NOP);
        @(negedge clk); #1;
        check("wrap_addr1", imem_addr2, 32'hFFFF_FFFC);
        @(posedge clk); #1;
        check("wrap_word0", instruction2, mem_word(32'hFFFF_FFF8));
        check("wrap_ppf0", pc_plus_four2, 32'hFFFF_FFFC);
        @(negedge clk); #1;
        check("wrap_addr2", imem_addr2, 32'h0);
        @(posedge clk); #1;
        check("wrap_ppf1", pc_plus_four2, 32'h0);
        check("wrap_word1", instruction2, mem_word(32'hFFFF_FFFC));
        @(posedge clk); #1;
        check("wrap_ppf2", pc_plus_four2, 32'h4);
        check("wrap_word2", instruction2, mem_word(32'h0));
        check("wrap_valid", {31'd0, if_valid2}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
